// File: rtl/softmax_pkg.sv
// Shared softmax datapath definitions: table geometry and the LUT loader state set.
package softmax_pkg;

  localparam int unsigned FLOAT_LEN = 16;
  localparam int unsigned MANT_LEN  = 10;
  localparam int unsigned LUT_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN,
    DONE
  } lut_ld_state_t;

endpackage

// File: rtl/softmax_lut_loader.sv
// LUT load sequencer: turns a host valid/ready stream into exactly LUT_DEPTH
// registered write beats shared by every divider's log2/exp2 tables.
module softmax_lut_loader
  import softmax_pkg::*;
#(
  parameter int unsigned FLOAT_LEN = softmax_pkg::FLOAT_LEN,
  parameter int unsigned MANT_LEN  = softmax_pkg::MANT_LEN,
  parameter int unsigned LUT_DEPTH = softmax_pkg::LUT_DEPTH,
  parameter int unsigned CNT_W     = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [MANT_LEN-1:0]  host_log2_data,
  input  logic [FLOAT_LEN-1:0] host_exp2_data,
  output logic                 lut_wr_en,
  output logic [MANT_LEN-1:0]  log2_lut_data_out,
  output logic [FLOAT_LEN-1:0] exp2_lut_data_out,
  output logic                 lut_ready,
  output logic                 load_done,
  output logic                 lut_err,
  output logic [FLOAT_LEN-1:0] lut_checksum
);

  lut_ld_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [MANT_LEN-1:0]  log2_q, log2_d;
  logic [FLOAT_LEN-1:0] exp2_q, exp2_d;
  logic [FLOAT_LEN-1:0] chk_q, chk_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 accept;

  assign host_ready        = (state_q == LOAD);
  assign lut_ready         = (state_q == DONE);
  assign lut_wr_en         = wr_en_q;
  assign log2_lut_data_out = log2_q;
  assign exp2_lut_data_out = exp2_q;
  assign lut_checksum      = chk_q;
  assign load_done         = done_q;
  assign lut_err           = err_q;

  // abort blocks acceptance in its own cycle so no beat slips out behind it
  assign accept = host_ready && host_valid && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    log2_d  = log2_q;
    exp2_d  = exp2_q;
    chk_d   = chk_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (accept) begin
      wr_en_d = 1'b1;
      log2_d  = host_log2_data;
      exp2_d  = host_exp2_data;
      chk_d   = chk_q + FLOAT_LEN'(host_log2_data) + host_exp2_data;
      cnt_d   = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          chk_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if (start) err_d = 1'b1;
          if (accept && cnt_q == CNT_W'(LUT_DEPTH - 1)) state_d = FIN;
        end
      end
      FIN: begin
        if (start) err_d = 1'b1;
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      log2_q  <= '0;
      exp2_q  <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      log2_q  <= log2_d;
      exp2_q  <= exp2_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_softmax_lut_loader.sv
// Randomized bench for softmax_lut_loader against a beat-counting table-load model.
module tb_softmax_lut_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [9:0]  host_log2_data = '0;
  logic [15:0] host_exp2_data = '0;
  logic        lut_wr_en;
  logic [9:0]  log2_lut_data_out;
  logic [15:0] exp2_lut_data_out;
  logic        lut_ready;
  logic        load_done;
  logic        lut_err;
  logic [15:0] lut_checksum;

  softmax_lut_loader #(.FLOAT_LEN(16), .MANT_LEN(10), .LUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_log2_data(host_log2_data), .host_exp2_data(host_exp2_data),
    .lut_wr_en(lut_wr_en), .log2_lut_data_out(log2_lut_data_out),
    .exp2_lut_data_out(exp2_lut_data_out), .lut_ready(lut_ready),
    .load_done(load_done), .lut_err(lut_err), .lut_checksum(lut_checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 accepting, 2 last write draining, 3 table ready.
  int          phase;
  int          beats;
  int          wr_count;
  bit          exp_wr, exp_done, exp_err;
  logic [9:0]  exp_l2;
  logic [15:0] exp_e2, exp_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    phase = 0; beats = 0; exp_wr = 0; exp_done = 0; exp_err = 0;
    exp_l2 = '0; exp_e2 = '0; exp_sum = '0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model.
  task automatic step(input bit st, input bit ab, input bit v,
                      input logic [9:0] l2, input logic [15:0] e2);
    bit acc;
    check("host_ready", host_ready, phase == 1);
    check("lut_ready", lut_ready, phase == 3);
    check("load_done", load_done, exp_done);
    check("lut_err", lut_err, exp_err);
    check("lut_wr_en", lut_wr_en, exp_wr);
    check("log2_out", log2_lut_data_out, exp_l2);
    check("exp2_out", exp2_lut_data_out, exp_e2);
    check("checksum", lut_checksum, exp_sum);
    if (lut_wr_en) wr_count++;

    start = st; abort = ab; host_valid = v;
    host_log2_data = l2; host_exp2_data = e2;

    acc = v && phase == 1 && !ab;
    exp_wr = acc;
    exp_done = 0;
    if (acc) begin
      exp_l2 = l2; exp_e2 = e2;
      exp_sum = exp_sum + {6'd0, l2} + e2;
      beats++;
    end
    case (phase)
      0, 3: if (st) begin phase = 1; beats = 0; exp_sum = '0; end
      1: begin
        if (ab) begin phase = 0; exp_err = 1; end
        else begin
          if (st) exp_err = 1;
          if (acc && beats == DEPTH) phase = 2;
        end
      end
      default: begin if (st) exp_err = 1; phase = 3; exp_done = 1; end
    endcase
    @(negedge clk);
  endtask

  // pat: 0 ramp, 1 zeros, 2 random. stall: 0 none, 1 every other cycle, 2 random.
  task automatic run_load(input int pat, input int stall, input int abort_at,
                          input int start_at, input int exp_writes);
    int k, cyc;
    bit v, ab, st, st_done;
    logic [9:0] l2;
    logic [15:0] e2;
    int done_pulses;
    k = 0; cyc = 0; st_done = 0; wr_count = 0; done_pulses = 0;
    step(1, 0, 0, '0, '0);
    while (phase != 3 && phase != 0 && cyc < 2000) begin
      case (stall)
        0: v = 1;
        1: v = (cyc[0] == 1'b0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ab = (abort_at >= 0 && k == abort_at);
      st = (start_at >= 0 && k == start_at && !st_done);
      if (st) st_done = 1;
      if (ab) v = 1;
      case (pat)
        0: begin l2 = 10'(k); e2 = 16'h3C00 + 16'(k); end
        1: begin l2 = '0; e2 = '0; end
        default: begin l2 = 10'($urandom); e2 = 16'($urandom); end
      endcase
      if (v && phase == 1 && !ab) k++;
      step(st, ab, v, l2, e2);
      cyc++;
    end
    check("load_bounded", cyc < 2000, 1);
    for (int i = 0; i < 3; i++) begin
      if (load_done) done_pulses++;
      step(0, 0, 0, 10'($urandom), 16'($urandom));
    end
    check("write_count", wr_count, exp_writes);
    if (exp_writes == DEPTH) check("done_pulses", done_pulses, 1);
  endtask

  initial begin
    reset_model();
    wr_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back ramp
    run_load(0, 0, -1, -1, DEPTH);
    check("sum_ramp", lut_checksum, 16'h0FC0);
    check("ready_ramp", lut_ready, 1);
    check("err_clean", lut_err, 0);
    step(0, 1, 0, '0, '0);   // abort in DONE is a no-op

    // alternating stalls, reload from DONE
    run_load(0, 1, -1, -1, DEPTH);
    check("sum_stall", lut_checksum, 16'h0FC0);

    // abort after 10 beats
    run_load(0, 0, 10, -1, 10);
    check("abort_idle", lut_ready, 0);
    check("abort_err", lut_err, 1);
    run_load(2, 2, -1, -1, DEPTH);
    check("err_sticky", lut_err, 1);
    check("ready_after", lut_ready, 1);

    // stray start mid-load
    run_load(0, 0, -1, 20, DEPTH);
    check("sum_midstart", lut_checksum, 16'h0FC0);

    // zero reload from DONE
    run_load(1, 2, -1, -1, DEPTH);
    check("sum_zero", lut_checksum, 16'h0000);

    // reset mid-load at beat 30
    wr_count = 0;
    step(1, 0, 0, '0, '0);
    for (int k = 0; k < 30; k++) step(0, 0, 1, 10'(k), 16'h3C00 + 16'(k));
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", lut_wr_en, 0);
    check("rst_ready", {host_ready, lut_ready, load_done, lut_err}, 0);
    check("rst_data", {log2_lut_data_out, exp2_lut_data_out}, 0);
    check("rst_sum", lut_checksum, 0);
    reset_model();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wr_count = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 1, 10'($urandom), 16'($urandom));
    check("no_wr_after_rst", wr_count, 0);
    run_load(0, 0, -1, -1, DEPTH);
    check("sum_after_rst", lut_checksum, 16'h0FC0);
    check("err_after_rst", lut_err, 0);

    // random stalls and abort points
    for (int r = 0; r < 4; r++) begin
      int a;
      a = (r[0] == 1'b1) ? $urandom_range(0, DEPTH - 1) : -1;
      run_load(2, 2, a, -1, (a >= 0) ? a : DEPTH);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
